rx: RTL
=======

Name: rx

Overview:
- Receive-side counterpart of the QPSK-branch polyphase RRC transmitter. It takes one signed baseband sample per clock at 4x oversampling.
- The sample goes through a 24-tap matched filter using the same RRC coefficient set. The result is decimated by 4 at a selectable sampling phase.
- A hard sign decision per symbol produces one recovered bit with a valid strobe.
- The block sits after the channel/loopback path, one instance per I/Q branch.

Parameters:
- DW, 8, input sample width (signed, two's complement)
- CW, 8, coefficient width (signed)
- NTAP, 24, matched-filter length
- OS, 4, oversampling factor (samples per symbol)
- MFW, 17, matched-filter output width. Worst case is 128 x sum|c| = 128 x 346 = 44288, so no overflow is possible.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_enable  in  1  sample-valid/clock-enable. When low, all state holds.
- i_rx  in  DW  signed input sample
- i_phase  in  2  decimation phase select, 0..OS-1
- o_mf  out  MFW  registered matched-filter output (signed, full precision)
- o_bit  out  1  recovered bit: 1 when the decided sample is >= 0, 0 when < 0
- o_valid  out  1  one-cycle strobe when o_bit is updated

Behaviour:
- Coefficients c[0..23] (hex, signed): 00 FE FF 00 02 00 FB F5 F9 0A 25 3E 48 3E 25 0A F9 F5 FB 00 02 00 FF FE. Signed sum is 242; absolute sum is 346.
- Reset (async, rst=1): delay line, o_mf, o_bit, o_valid and the phase counter all go to 0.
- Delay line: x[0..23]. On a clk edge with i_enable=1: x[0] <= i_rx and x[k] <= x[k-1].
- Filter: the combinational sum is S = sum_k c[k]*x[k], with full-precision signed products (DW+CW bits). On the same enabled edge, o_mf <= S computed from the pre-edge delay line. Latency is therefore i_rx at edge n -> contribution visible on o_mf after edge n+1.
- Phase counter: 2-bit counter cnt, incremented modulo OS on every enabled edge, wraps 3 -> 0.
- Decision:
  - On an enabled edge where cnt == i_phase: o_bit <= ~S[MFW-1] and o_valid <= 1.
  - On every other edge: o_valid <= 0 and o_bit holds.
  - The decision uses the same S that is written to o_mf on that edge, so o_bit and o_mf stay consistent.
- i_enable=0:
  - Delay line, cnt, o_mf and o_bit hold.
  - o_valid <= 0, so no strobe is repeated.
- i_phase change mid-stream:
  - Sampled every cycle; the new value takes effect at the next compare.
  - Spacing between strobes can be 1..7 enabled cycles once. After that it is exactly OS.
  - No other side effect.
- S == 0 decides as bit 1.
- Reset mid-stream: all state clears immediately.
  - The first valid strobe after release is on the first enabled edge with cnt == i_phase. With i_phase=0 this is the first enabled edge.
  - Until 24 new samples have entered, decisions are made on a partially zero-filled line; this is accepted.

Decomposition:
- Shared package rrc_pkg holds:
  - NTAP, OS, CW
  - the coefficient constant array, shared with tx
  - MFW
- One natural sub-module, rx_mf: delay line, MAC sum and o_mf register, with an enable input.
- The rx top holds the phase counter and the decision/strobe logic.

Test Plan:
- Impulse: reset, then i_rx=+127 for one enabled cycle, then zeros, enable held high.
  - o_mf must read 127*c[k] for k=0..23 on consecutive cycles.
  - Peak is 9144 at k=12; o_mf returns to 0 after 24 cycles.
- Full scale:
  - i_rx=+127 held for 30 cycles -> o_mf settles at 30734 and o_bit=1 at every strobe.
  - i_rx=-128 held -> o_mf settles at -30976 and o_bit=0.
- Strobe/phase: constant input with i_phase=2.
  - o_valid pulses exactly every 4 cycles, each pulse on an edge where cnt=2.
  - Switching i_phase to 0 mid-run gives one irregular gap, then strict period 4.
- Enable gating: toggle i_enable 1010...
  - o_mf/cnt advance only on enabled edges.
  - Strobe count equals enabled edges / 4.
  - o_valid is never high for 2 consecutive cycles.
- Loopback:
  - Setup: tx fed with PRBS7 bits, i_rx = tx output [7:0], i_phase swept 0..3.
  - At the best phase, the recovered stream matches PRBS7 at a fixed measured delay with 0 errors over 1000 symbols.
- Async reset: assert rst mid-stream, asynchronously between edges.
  - All outputs are 0 before the next clk edge.
  - After release, behaviour is identical to a fresh start: the impulse test is reproduced bit-exactly.

Source files
------------

// File: rtl/rrc_pkg.sv
// Shared RRC constants for the polyphase transmitter and the receive-side matched filter.
// The coefficient table is the single source for both directions of the link.
package rrc_pkg;

  localparam int NTAP = 24;
  localparam int OS   = 4;
  localparam int CW   = 8;
  localparam int MFW  = 17;

  localparam logic signed [CW-1:0] COEF [NTAP] = '{
    8'sh00, 8'shFE, 8'shFF, 8'sh00, 8'sh02, 8'sh00, 8'shFB, 8'shF5,
    8'shF9, 8'sh0A, 8'sh25, 8'sh3E, 8'sh48, 8'sh3E, 8'sh25, 8'sh0A,
    8'shF9, 8'shF5, 8'shFB, 8'sh00, 8'sh02, 8'sh00, 8'shFF, 8'shFE
  };

endpackage

// File: rtl/rx_mf.sv
// Matched filter: sample delay line, full-precision MAC and registered filter output.
// The combinational sum is also exported so the decision uses the value being registered.
module rx_mf
  import rrc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic signed [DW-1:0]  sample,
  output logic signed [MFW-1:0] sum,
  output logic signed [MFW-1:0] mf
);

  logic signed [DW-1:0]    x_r [NTAP];
  logic signed [MFW-1:0]   mf_r;
  logic signed [MFW-1:0]   sum_s;
  logic signed [DW+CW-1:0] prod_s;

  // shift the delay line on enabled samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) begin
        x_r[k] <= '0;
      end
    end else if (enable) begin
      x_r[0] <= sample;
      for (int k = 1; k < NTAP; k++) begin
        x_r[k] <= x_r[k-1];
      end
    end
  end

  // products are exact in DW+CW bits and the worst-case sum fits MFW bits
  always_comb begin
    sum_s  = '0;
    prod_s = '0;
    for (int k = 0; k < NTAP; k++) begin
      prod_s = x_r[k] * COEF[k];
      sum_s  = sum_s + MFW'(prod_s);
    end
  end

  // register the filter output from the pre-edge delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mf_r <= '0;
    end else if (enable) begin
      mf_r <= sum_s;
    end
  end

  assign sum = sum_s;
  assign mf  = mf_r;

endmodule

// File: rtl/rx.sv
// Receive branch: matched filter, decimation by OS at a selectable phase and hard sign decision.
// One instance per I/Q branch.
module rx
  import rrc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic signed [DW-1:0]  i_rx,
  input  logic [1:0]            i_phase,
  output logic signed [MFW-1:0] o_mf,
  output logic                  o_bit,
  output logic                  o_valid
);

  logic signed [MFW-1:0] sum_s;
  logic [1:0]            cnt_r;
  logic                  bit_r;
  logic                  valid_r;

  rx_mf #(.DW(DW)) u_mf (
    .clk    (clk),
    .rst    (rst),
    .enable (i_enable),
    .sample (i_rx),
    .sum    (sum_s),
    .mf     (o_mf)
  );

  // phase counter and sign decision; a strobe never repeats on a held cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (i_enable) begin
      cnt_r <= (cnt_r == 2'(OS-1)) ? 2'd0 : cnt_r + 2'd1;
      if (cnt_r == i_phase) begin
        bit_r   <= ~sum_s[MFW-1];
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign o_bit   = bit_r;
  assign o_valid = valid_r;

endmodule
